// File: rtl/operand_loader_pkg.sv
// Shared definitions for the operand loader and the 4-bit adder datapath around it.
// Holds the FSM state codes that are also shown on the board LEDs.
package operand_loader_pkg;

    localparam int WIDTH_DEF = 4;

    typedef enum logic [1:0] {
        WAIT_A  = 2'b00,
        WAIT_B  = 2'b01,
        PRESENT = 2'b10
    } state_t;

endpackage

// File: rtl/operand_loader_if.sv
// Operand loader bus: switch/button/clear inputs and the registered operand pair.
// The master modport is the board side, the slave modport is the loader itself.
interface operand_loader_if
    import operand_loader_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
);
    logic [WIDTH-1:0] Sw;
    logic             Btn;
    logic             Clr;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Valid;
    logic [1:0]       State;

    modport master (output Sw, Btn, Clr, input A, B, Valid, State);
    modport slave  (input Sw, Btn, Clr, output A, B, Valid, State);
endinterface

// File: rtl/operand_loader_btn_conditioner.sv
// Button conditioner: 2-flop synchroniser, optional debounce (OPERAND_LOADER_DEBOUNCE_EN), rising-edge detect.
// Latency: press 2 cycles after Btn rise (plus DEBOUNCE_CYCLES when debounced); no backpressure, one pulse per press.
module btn_conditioner #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic Btn,
    output logic press
);

    logic sync1;
    logic sync2;
    logic level;
    logic prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= Btn;
            sync2 <= sync1;
        end
    end

`ifdef OPERAND_LOADER_DEBOUNCE_EN
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [CW-1:0] cnt;
    logic          deb;

    // Level flips only after DEBOUNCE_CYCLES consecutive mismatching samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            deb <= 1'b0;
        end else if (sync2 != deb) begin
            if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                deb <= sync2;
                cnt <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end else begin
            cnt <= '0;
        end
    end

    assign level = deb;
`else
    assign level = sync2;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev <= 1'b0;
        end else begin
            prev <= level;
        end
    end

    assign press = level & ~prev;

endmodule

// File: rtl/operand_loader.sv
// Operand loader: press 1 loads A, press 2 loads B and raises Valid; debounce via OPERAND_LOADER_DEBOUNCE_EN.
// Latency: capture on the 3rd edge after Btn rise (3 + DEBOUNCE_CYCLES when debounced); no backpressure, Clr wins.
module operand_loader
    import operand_loader_pkg::*;
#(
    parameter int WIDTH           = WIDTH_DEF,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    operand_loader_if.slave   bus
);

    logic             press;
    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             valid_q, valid_d;

    btn_conditioner #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_btn (
        .clk   (clk),
        .rst_n (rst_n),
        .Btn   (bus.Btn),
        .press (press)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= WAIT_A;
            a_q     <= '0;
            b_q     <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            valid_q <= valid_d;
        end
    end

    // A press coinciding with Clr is dropped, not held over.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        valid_d = valid_q;
        if (bus.Clr) begin
            state_d = WAIT_A;
            a_d     = '0;
            b_d     = '0;
            valid_d = 1'b0;
        end else begin
            case (state_q)
                WAIT_A: if (press) begin
                    a_d     = bus.Sw;
                    state_d = WAIT_B;
                end
                WAIT_B: if (press) begin
                    b_d     = bus.Sw;
                    valid_d = 1'b1;
                    state_d = PRESENT;
                end
                PRESENT: if (press) begin
                    a_d     = bus.Sw;
                    valid_d = 1'b0;
                    state_d = WAIT_B;
                end
                default: state_d = WAIT_A;
            endcase
        end
    end

    assign bus.A     = a_q;
    assign bus.B     = b_q;
    assign bus.Valid = valid_q;
    assign bus.State = state_q;

endmodule
